// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the MEM stage (master) and the data-memory
// responder (slave). A request is taken on a valid/ready handshake; the
// responder answers with a one-cycle resp_valid pulse and drives stall while
// the access is outstanding.
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_we;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        stall;

   modport master (
      output req_valid,
      output req_we,
      output req_addr,
      output req_wdata,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  stall
   );

   modport slave (
      input  req_valid,
      input  req_we,
      input  req_addr,
      input  req_wdata,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output stall
   );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder. Accepts one load/store at a time, waits a
// fixed LATENCY (1..15) cycles, then pulses resp_valid with the read data (or
// zero for a store). The word array is deliberately not reset so its contents
// survive rst_n; a reset in the middle of an access simply drops that access.
module data_mem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 3
) (
   input logic                 clk,
   input logic                 rst_n,
   data_mem_responder_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int         DEPTH    = 1 << ADDR_W;
   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   state_t              state;
   logic [3:0]          cnt;
   logic                lat_we;
   logic [ADDR_W-1:0]   lat_addr;
   logic [15:0]         lat_wdata;
   logic                resp_valid_q;
   logic [15:0]         resp_rdata_q;
   logic [15:0]         mem [DEPTH];

   logic                commit;
   logic                acc_we;
   logic [ADDR_W-1:0]   acc_addr;
   logic [15:0]         acc_wdata;

   // Upper address bits alias onto the same word and are intentionally dropped.
   logic                unused_addr_hi;
   assign unused_addr_hi = ^bus.req_addr[15:ADDR_W];

   // Pick the access fields (live request when finishing straight from IDLE,
   // latched copy otherwise) and flag the edge that completes the access.
   always_comb begin
      commit    = 1'b0;
      acc_we    = lat_we;
      acc_addr  = lat_addr;
      acc_wdata = lat_wdata;
      if (state == IDLE) begin
         acc_we    = bus.req_we;
         acc_addr  = bus.req_addr[ADDR_W-1:0];
         acc_wdata = bus.req_wdata;
         commit    = bus.req_valid && (LATENCY == 1);
      end else if (state == BUSY) begin
         commit = (cnt == 4'd1);
      end
   end

   // Control FSM: latch the request on accept, count down the latency, and
   // register the response pulse and read data on the completing edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         lat_we       <= 1'b0;
         lat_addr     <= '0;
         lat_wdata    <= 16'h0000;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= 16'h0000;
      end else begin
         resp_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  lat_we    <= bus.req_we;
                  lat_addr  <= bus.req_addr[ADDR_W-1:0];
                  lat_wdata <= bus.req_wdata;
                  if (LATENCY == 1) begin
                     state <= RESP;
                  end else begin
                     cnt   <= CNT_LOAD;
                     state <= BUSY;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) begin
                  state <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
         if (commit) begin
            resp_valid_q <= 1'b1;
            resp_rdata_q <= acc_we ? 16'h0000 : mem[acc_addr];
         end
      end
   end

   // Word array write port; a store lands on the same edge its response is
   // produced, and never while reset is asserted so an aborted store is lost.
   always_ff @(posedge clk) begin
      if (rst_n && commit && acc_we) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.stall      = (state == BUSY) || ((state == IDLE) && bus.req_valid);
   assign bus.resp_valid = resp_valid_q;
   assign bus.resp_rdata = resp_rdata_q;

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder that services load/store requests from the pipeline's MEM stage. It sits on the memory side of the MEM_Unit interface: it accepts one request at a time through a valid/ready handshake, models a fixed access latency, returns read data or a write acknowledge, and drives a stall line the hazard logic uses to freeze the pipeline while an access is outstanding.

## Interface
- ADDR_W, 8, word-address bits used; depth = 2^ADDR_W 16-bit words
- LATENCY, 3, cycles from accept edge to resp_valid; legal range 1..15

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  MEM stage has a request (mem_to_reg or reg_to_mem asserted)
- req_we  in  1  1 = store (reg_to_mem), 0 = load (mem_to_reg)
- req_addr  in  16  word address (ALU result); only [ADDR_W-1:0] used
- req_wdata  in  16  store data
- req_ready  out  1  responder can accept a request this cycle
- resp_valid  out  1  one-cycle pulse: access complete
- resp_rdata  out  16  load data, valid while resp_valid=1
- stall  out  1  hold IF/ID/EX/MEM stages this cycle

## Operation
- States: IDLE, BUSY, RESP. Registered: state, 4-bit down-counter cnt, latched we/addr/wdata, resp_rdata.
- IDLE: req_ready=1. On a rising edge with req_valid=1: latch req_we, req_addr[ADDR_W-1:0], req_wdata; if LATENCY=1 go RESP, else load cnt=LATENCY-1 and go BUSY.
- BUSY: req_ready=0. cnt decrements each edge; on the edge where cnt=1, go RESP. BUSY therefore lasts exactly LATENCY-1 cycles.
- Transition into RESP (same edge): load: resp_rdata <= mem[addr]; store: mem[addr] <= wdata, resp_rdata <= 16'h0000.
- RESP: resp_valid=1, req_ready=0, stall=0; next edge unconditionally to IDLE.
- stall = (state==BUSY) | (state==IDLE & req_valid). Low in RESP, so the pipeline advances past the completed instruction at the RESP edge.
- Address aliasing: req_addr[15:ADDR_W] ignored; addresses differing only in those bits hit the same word.
- req_valid while req_ready=0 is ignored (not queued); request fields sampled only at the accept edge, so changes afterwards have no effect.
- Memory array is not reset; contents persist across rst_n.
- resp_rdata holds its value outside RESP until the next RESP load.

## Timing
- Reset (async, immediate on rst_n=0): state=IDLE, cnt=0, resp_valid=0, resp_rdata=0, req_ready=1 once rst_n=1, stall=req_valid (combinational). Reset mid-BUSY aborts the access; a pending store is discarded, array unchanged.
- Accept at edge k -> resp_valid high during cycle after edge k+LATENCY-1, i.e. LATENCY cycles after accept, for exactly one cycle.
- Throughput: one request per LATENCY+1 cycles; back-to-back request accepted at the edge ending the IDLE cycle that follows RESP.
- stall high for LATENCY cycles per access (IDLE-with-request cycle plus BUSY cycles).
- Read-after-write: store committed at its RESP-entry edge; any later load to the same word returns the new data.
- All outputs except stall and req_ready are registered; req_ready and stall are decoded from state (and req_valid) only.

## Test plan
- Reset: drive rst_n=0 mid-BUSY of a store of 16'hBEEF to addr 5 -> state IDLE, resp_valid=0, resp_rdata=0 immediately; later load addr 5 returns prior contents, not BEEF.
- Store/load LATENCY=3: store 16'h1234 to addr 16'h0010, then load 16'h0010 -> each resp_valid exactly 3 cycles after accept, load resp_rdata=16'h1234, store resp_rdata=0, stall high 3 cycles each.
- LATENCY=1: load accepted at edge k -> resp_valid in cycle after edge k, BUSY never entered, stall high 1 cycle.
- Aliasing ADDR_W=8: store 16'hA5A5 to 16'h0103, load 16'h0003 -> returns 16'hA5A5.
- Ignored request: hold req_valid=1 with changing addr/wdata during BUSY -> only the accept-edge values used; next accept occurs in IDLE after RESP; throughput one per LATENCY+1 cycles over 8 back-to-back loads.
- LATENCY=15: counter boundary -> resp_valid exactly 15 cycles after accept, single-cycle pulse, no wrap of cnt.
